systolic_ctrl_nxn: RTL and testbench

Parametrised sequencer for an N x N output-stationary systolic array: the next generation of the fixed 4x4 controller. It issues skewed A/B load slots, pump (shift) cycles, and row/column readout. It adds a start/done handshake, load-side stalling on source valid, output backpressure, and a weight-reuse mode that skips reloading B. It sits between the operand RAM address generator, the PE array and the result drain path.

---
 rtl/systolic_ctrl_nxn.sv | 167 ++++++++++++++++
 tb/tb_systolic_ctrl_nxn.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl_nxn.sv
// Sequencer for an N x N output-stationary systolic array.
// It issues skewed A/B operand load slots, then a fixed run of shift cycles,
// then a row-major result readout. Loads stall on the source valid signal and
// readout stalls on drain backpressure. B can be kept resident between jobs.
//
// state  | meaning
// IDLE   | waiting for start; all outputs low
// LOAD_A | stepping skewed A slots, one per cycle with load_valid
// LOAD_B | stepping skewed B slots (skipped when B is reused)
// PUMP   | PUMP_LEN shift/MAC cycles, not stallable
// OUT    | presenting results row by row, advancing on out_ready
module systolic_ctrl_nxn #(
    parameter int N        = 4,
    parameter int PUMP_LEN = 16,
    parameter int ID_W     = $clog2(2*N-1),
    parameter int ROW_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             reuse_b,
    input  logic             load_valid,
    output logic             load_a,
    output logic             load_b,
    output logic [ID_W-1:0]  load_id,
    output logic [ROW_W-1:0] load_row,
    output logic             shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [ROW_W-1:0] out_col,
    output logic             busy,
    output logic             done
);

    localparam int PC_W = (PUMP_LEN > 1) ? $clog2(PUMP_LEN) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(N-1);
    localparam logic [ID_W-1:0]  ID_FIRST  = ID_W'(N-1);
    localparam logic [ID_W-1:0]  ID_TOP    = ID_W'(2*N-2);
    localparam logic [PC_W-1:0]  PUMP_INIT = PC_W'(PUMP_LEN-1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_PUMP   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] slot_row;
    logic [ID_W-1:0]  slot_id;
    logic [PC_W-1:0]  pump_cnt;
    logic [ROW_W-1:0] o_row;
    logic [ROW_W-1:0] o_col;
    logic             reuse_lat;
    logic             b_resident;
    logic             done_q;

    logic [ID_W-1:0]  id_row_end;
    logic [ID_W-1:0]  id_next_start;
    logic             slot_row_end;
    logic             slot_last;
    logic             out_last;
    logic             in_load;

    // Slot boundaries: row r covers ids N-1-r .. 2N-2-r, so the last row ends at N-1.
    always_comb begin
        id_row_end    = ID_TOP - ID_W'(slot_row);
        id_next_start = ID_FIRST - ID_W'(slot_row) - ID_W'(1);
        slot_row_end  = (slot_id == id_row_end);
        slot_last     = slot_row_end && (slot_row == ROW_LAST);
        out_last      = (o_row == ROW_LAST) && (o_col == ROW_LAST);
        in_load       = (state == S_LOAD_A) || (state == S_LOAD_B);
    end

    // Moore decode of state and counters; load strobes qualify with load_valid.
    always_comb begin
        load_a    = (state == S_LOAD_A) && load_valid;
        load_b    = (state == S_LOAD_B) && load_valid;
        load_id   = in_load ? slot_id : '0;
        load_row  = in_load ? slot_row : '0;
        shift     = (state == S_PUMP);
        out_valid = (state == S_OUT);
        out_row   = (state == S_OUT) ? o_row : '0;
        out_col   = (state == S_OUT) ? o_col : '0;
        busy      = (state != S_IDLE);
        done      = done_q;
    end

    // Main sequencer: state, slot walk, pump down-counter, readout walk, done pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            slot_row   <= '0;
            slot_id    <= '0;
            pump_cnt   <= '0;
            o_row      <= '0;
            o_col      <= '0;
            reuse_lat  <= 1'b0;
            b_resident <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD_A;
                        // A reuse request is only meaningful once B has been loaded.
                        reuse_lat <= reuse_b && b_resident;
                        slot_row  <= '0;
                        slot_id   <= ID_FIRST;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (load_valid) begin
                        if (slot_last) begin
                            slot_row <= '0;
                            slot_id  <= ID_FIRST;
                            if ((state == S_LOAD_A) && !reuse_lat) begin
                                state <= S_LOAD_B;
                            end else begin
                                state    <= S_PUMP;
                                pump_cnt <= PUMP_INIT;
                                if (state == S_LOAD_B) begin
                                    b_resident <= 1'b1;
                                end
                            end
                        end else if (slot_row_end) begin
                            slot_row <= slot_row + ROW_W'(1);
                            slot_id  <= id_next_start;
                        end else begin
                            slot_id <= slot_id + ID_W'(1);
                        end
                    end
                end
                S_PUMP: begin
                    if (pump_cnt == '0) begin
                        state <= S_OUT;
                        o_row <= '0;
                        o_col <= '0;
                    end else begin
                        pump_cnt <= pump_cnt - PC_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                            o_row  <= '0;
                            o_col  <= '0;
                        end else if (o_col == ROW_LAST) begin
                            o_col <= '0;
                            o_row <= o_row + ROW_W'(1);
                        end else begin
                            o_col <= o_col + ROW_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl_nxn.sv
// Self-checking bench for systolic_ctrl_nxn: a table of jobs (N=4) with
// expected phase timing, a load/readout scoreboard, plus hand-written
// reset and N=3 sequences.
module tb_systolic_ctrl_nxn;
    localparam int N   = 4;
    localparam int PL  = 16;
    localparam int IDW = $clog2(2*N-1);
    localparam int RW  = $clog2(N);
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0, reuse_b = 1'b0, load_valid = 1'b0, out_ready = 1'b0;
    logic load_a, load_b, shift, out_valid, busy, done;
    logic [IDW-1:0] load_id;
    logic [RW-1:0]  load_row, out_row, out_col;

    logic start3 = 1'b0, reuse3 = 1'b0, lv3 = 1'b0, ordy3 = 1'b0;
    logic load_a3, load_b3, shift3, ov3, busy3, done3;
    logic [2:0] load_id3;
    logic [1:0] load_row3, out_row3, out_col3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    systolic_ctrl_nxn #(.N(N), .PUMP_LEN(PL)) dut (
        .clk(clk), .rstn(rstn), .start(start), .reuse_b(reuse_b),
        .load_valid(load_valid), .load_a(load_a), .load_b(load_b),
        .load_id(load_id), .load_row(load_row), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .busy(busy), .done(done)
    );

    systolic_ctrl_nxn #(.N(3), .PUMP_LEN(2)) dut3 (
        .clk(clk), .rstn(rstn), .start(start3), .reuse_b(reuse3),
        .load_valid(lv3), .load_a(load_a3), .load_b(load_b3),
        .load_id(load_id3), .load_row(load_row3), .shift(shift3),
        .out_valid(ov3), .out_ready(ordy3), .out_row(out_row3),
        .out_col(out_col3), .busy(busy3), .done(done3)
    );

    typedef struct {
        int reuse; int b_skip; int chain;
        int lv_lo; int lv_len; int or_lo; int or_len;
        int a_first; int a_last; int b_first; int b_last;
        int s_first; int s_last; int o_first; int o_last; int done_cyc;
    } job_t;

    job_t jobs[5];
    int   lq[$];
    int   oq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({load_a, load_b, shift, out_valid, busy, done,
                     load_id, load_row, out_row, out_col});
    endfunction

    task automatic idle_check(input string nm);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " idle outputs"}, all_outs(), 0);
    endtask

    // Starts a job from the current point (just after a negedge) and runs it
    // until the done cycle has been sampled.
    task automatic run_job(input job_t j, input int jn);
        int a_f, a_l, b_f, b_l, s_f, s_l, o_f, o_l;
        int a_n, b_n, s_n, o_n, dc, e, act;
        a_f = 0; a_l = 0; b_f = 0; b_l = 0; s_f = 0; s_l = 0; o_f = 0; o_l = 0;
        a_n = 0; b_n = 0; s_n = 0; o_n = 0; dc = 0;
        for (int m = 0; m < 2; m++)
            if (m == 0 || j.b_skip == 0)
                for (int r = 0; r < N; r++)
                    for (int k = 0; k < N; k++)
                        lq.push_back(m*100 + r*10 + (N-1-r+k));
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                oq.push_back(r*10 + c);
        start = 1'b1; reuse_b = j.reuse[0]; load_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reuse_b = 1'b0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            load_valid = !(j.lv_len > 0 && cyc >= j.lv_lo && cyc < j.lv_lo + j.lv_len);
            out_ready  = !(j.or_len > 0 && cyc >= j.or_lo && cyc < j.or_lo + j.or_len);
            @(negedge clk);
            act = int'(load_b)*100 + int'(load_row)*10 + int'(load_id);
            if (load_a || load_b) begin
                if (lq.size() == 0) chk($sformatf("j%0d load_extra", jn), 0, 1);
                else begin
                    e = lq.pop_front();
                    chk($sformatf("j%0d slot c%0d", jn, cyc), act, e);
                end
            end
            if (!load_valid) begin
                chk($sformatf("j%0d stall_strobe c%0d", jn, cyc), int'(load_a | load_b), 0);
                if (lq.size() > 0)
                    chk($sformatf("j%0d stall_slot c%0d", jn, cyc), int'(load_row)*10 + int'(load_id), lq[0] % 100);
            end
            if (!out_ready) begin
                chk($sformatf("j%0d bp_valid c%0d", jn, cyc), int'(out_valid), 1);
                if (oq.size() > 0)
                    chk($sformatf("j%0d bp_cell c%0d", jn, cyc), int'(out_row)*10 + int'(out_col), oq[0]);
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) chk($sformatf("j%0d out_extra", jn), 0, 1);
                else begin
                    e = oq.pop_front();
                    chk($sformatf("j%0d cell c%0d", jn, cyc), int'(out_row)*10 + int'(out_col), e);
                end
            end
            if (load_a) begin if (a_f == 0) a_f = cyc; a_l = cyc; a_n++; end
            if (load_b) begin if (b_f == 0) b_f = cyc; b_l = cyc; b_n++; end
            if (shift) begin if (s_f == 0) s_f = cyc; s_l = cyc; s_n++; end
            if (out_valid) begin if (o_f == 0) o_f = cyc; o_l = cyc; o_n++; end
            if (done) begin
                dc = cyc;
                chk($sformatf("j%0d busy_at_done", jn), int'(busy), 0);
                break;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("j%0d done_cycle", jn), dc, j.done_cyc);
        chk($sformatf("j%0d a_first", jn), a_f, j.a_first);
        chk($sformatf("j%0d a_last", jn), a_l, j.a_last);
        chk($sformatf("j%0d b_first", jn), b_f, j.b_first);
        chk($sformatf("j%0d b_last", jn), b_l, j.b_last);
        chk($sformatf("j%0d s_first", jn), s_f, j.s_first);
        chk($sformatf("j%0d s_last", jn), s_l, j.s_last);
        chk($sformatf("j%0d o_first", jn), o_f, j.o_first);
        chk($sformatf("j%0d o_last", jn), o_l, j.o_last);
        chk($sformatf("j%0d a_count", jn), a_n, N*N);
        chk($sformatf("j%0d b_count", jn), b_n, (j.b_skip != 0) ? 0 : N*N);
        chk($sformatf("j%0d shift_count", jn), s_n, PL);
        chk($sformatf("j%0d load_left", jn), lq.size(), 0);
        chk($sformatf("j%0d out_left", jn), oq.size(), 0);
        lq.delete();
        oq.delete();
    endtask

    initial begin
        int dc3;
        int e;
        // reuse b_skip chain lv_lo lv_len or_lo or_len | a b shift out done
        jobs[0] = '{1, 0, 0, 0, 0, 0, 0, 1, 16, 17, 32, 33, 48, 49, 64, 65};
        jobs[1] = '{1, 1, 1, 0, 0, 0, 0, 1, 16, 0, 0, 17, 32, 33, 48, 49};
        jobs[2] = '{0, 0, 0, 6, 5, 0, 0, 1, 21, 22, 37, 38, 53, 54, 69, 70};
        jobs[3] = '{0, 0, 0, 0, 0, 58, 3, 1, 16, 17, 32, 33, 48, 49, 67, 68};
        jobs[4] = '{1, 0, 0, 0, 0, 0, 0, 1, 16, 17, 32, 33, 48, 49, 64, 65};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset outputs", all_outs(), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset idle", all_outs(), 0);

        for (int i = 0; i < 4; i++) begin
            run_job(jobs[i], i);
            if (jobs[i].chain == 0) idle_check($sformatf("j%0d", i));
        end

        // Reset in the middle of PUMP of a reuse job (B resident, so PUMP is 17-32).
        start = 1'b1; reuse_b = 1'b1; load_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reuse_b = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 18) chk("rst_job shift c18", int'(shift), 1);
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_reset outputs", all_outs(), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mid_reset no_done", int'(done | busy), 0);
        end
        run_job(jobs[4], 4);
        idle_check("j4");

        // N=3, PUMP_LEN=2: slot order for A then B, done at cycle 30.
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    lq.push_back(m*100 + r*10 + (2-r+k));
        start3 = 1'b1; lv3 = 1'b1; ordy3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        dc3 = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (load_a3 || load_b3) begin
                if (lq.size() == 0) chk("n3 load_extra", 0, 1);
                else begin
                    e = lq.pop_front();
                    chk($sformatf("n3 slot c%0d", cyc),
                        int'(load_b3)*100 + int'(load_row3)*10 + int'(load_id3), e);
                end
            end
            if (done3) begin dc3 = cyc; break; end
            @(posedge clk); #1;
        end
        chk("n3 done_cycle", dc3, 30);
        chk("n3 load_left", lq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
